mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the processor's data-memory port and the data RAM.
- Replaces the fixed "one register drives the LEDs" wiring with addressable output registers, a debounced button block with sticky edge capture, and a free-running timer.
- Sits in the top-level wrapper. The processor's wren/address_dmem/data/q_dmem connect here; this block drives the RAM and board I/O.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width; RAM region is addresses 0 .. 2^ADDR_WIDTH-1.
- IO_BASE, 32'h0000_F000, base word address of the I/O region.
- NUM_OUT, 2, number of 32-bit output registers (1..16).
- NUM_BTN, 4, number of button inputs (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button change (10 ms at 50 MHz).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- address_dmem  in  32  processor data word address.
- data  in  32  processor store data.
- wren  in  1  processor store strobe.
- q_dmem  out  32  load data to processor.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_dataIn  out  32  RAM write data.
- ram_dataOut  in  32  RAM read data (synchronous, 1-cycle latency).
- btn  in  NUM_BTN  raw asynchronous buttons.
- out_regs  out  NUM_OUT*32  output registers, reg i on bits [32i+31:32i].
- irq  out  1  OR of all sticky edge bits.

Behaviour:
Address decode (combinational):
- RAM hit when address_dmem < 2^ADDR_WIDTH.
- IO hit when address_dmem[31:8] == IO_BASE[31:8].
- Any other address is unmapped.
- ram_addr = address_dmem[ADDR_WIDTH-1:0].
- ram_dataIn = data.
- ram_wEn = wren & RAM hit.

I/O map (offset = address_dmem[7:0]):
- 0x00..0x00+NUM_OUT-1: OUT[i], R/W.
- 0x10: BTN_LEVEL, RO, debounced levels, upper bits read 0.
- 0x11: BTN_EDGE, sticky rising edges, write-1-to-clear.
- 0x12: TIMER, R/W; a write loads the timer.
- Any other IO offset reads 0; writes to it are ignored.

Read path:
- Load data appears on q_dmem exactly 1 cycle after the address, for every region.
- On each posedge, register the region select (RAM/IO/unmapped) and the IO read value.
- q_dmem = ram_dataOut if the registered select is RAM, else the registered IO value, else 0.

Writes:
- Take effect at the posedge where wren=1.
- A write to OUT[i] is visible on out_regs the next cycle.

Button path, per bit:
- 2-flop synchroniser feeds a debounce counter.
- While sync != level, the counter increments; otherwise it clears to 0.
- When the counter reaches DEBOUNCE_CYCLES-1 with sync still != level: level <= sync and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
- A level 0->1 transition sets the corresponding BTN_EDGE bit.

BTN_EDGE write:
- Bits where data=1 clear.
- If a set and a clear hit the same bit in the same cycle, the set wins.

TIMER:
- Increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0.
- A write loads data; the next cycle reads data, and it then continues incrementing from data.
- Load takes priority over increment.
- A read returns the value registered at the address cycle.

irq = |BTN_EDGE, registered, so it follows the edge bits with no extra delay.

Reset (asynchronous, any time, including mid-debounce or mid-load):
- out_regs=0, BTN_LEVEL=0, BTN_EDGE=0, TIMER=0.
- Debounce counters and synchronisers = 0; q_dmem=0; irq=0.
- ram_wEn is forced 0 while reset is high.
- RAM contents are not cleared.
- On deassertion, the first posedge counts normally.

Simultaneous events: a load of BTN_EDGE in the same cycle as a clear-write returns the pre-clear value.

Test Plan:
- RAM passthrough: write 32'hDEAD_BEEF to address 5, then read address 5 -> q_dmem=32'hDEAD_BEEF one cycle after the read address; ram_wEn high only on the write cycle.
- Output registers (NUM_OUT=2): write 32'h1234 to IO_BASE+0 and 32'hABCD to IO_BASE+1 -> out_regs={32'hABCD,32'h1234} next cycle; readback matches. Writes to IO_BASE+0x05 and to address 32'h0000_2000 change nothing and read 0.
- Debounce (DEBOUNCE_CYCLES=4): btn[0] high for 3 cycles then low -> BTN_LEVEL stays 0. btn[0] held high -> BTN_LEVEL[0]=1 after 2 sync + 4 stable cycles, BTN_EDGE[0]=1, irq=1.
- Edge clear race: with BTN_EDGE=4'b0001, write 4'b0001 to IO_BASE+0x11 in the same cycle btn[1]'s level rises -> BTN_EDGE=4'b0010, irq stays 1. A second clear write -> 0, irq=0.
- Timer: write 32'hFFFF_FFFE to IO_BASE+0x12 -> reads on consecutive cycles return FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Reset mid-operation: assert reset asynchronously between clocks while out_regs!=0 and a debounce count is in progress -> all outputs 0 immediately; after release, the button needs a full DEBOUNCE_CYCLES window again.

Source files
------------

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: decodes processor data-memory accesses into the data RAM and a
// small I/O block made of output registers, debounced buttons with sticky
// rising-edge capture, and a free-running loadable timer. Every load returns
// one cycle after its address, whether it hit RAM, I/O or nothing.
module mmio_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter logic [31:0] IO_BASE         = 32'h0000_F000,
  parameter int unsigned NUM_OUT         = 2,
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             address_dmem,
  input  logic [31:0]             data,
  input  logic                    wren,
  output logic [31:0]             q_dmem,
  output logic                    ram_wEn,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [31:0]             ram_dataIn,
  input  logic [31:0]             ram_dataOut,
  input  logic [NUM_BTN-1:0]      btn,
  output logic [NUM_OUT*32-1:0]   out_regs,
  output logic                    irq
);

  localparam logic [32:0] RAM_LIMIT = 33'd1 << ADDR_WIDTH;
  localparam logic [7:0]  OFF_LEVEL = 8'h10;
  localparam logic [7:0]  OFF_EDGE  = 8'h11;
  localparam logic [7:0]  OFF_TIMER = 8'h12;

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned       CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Which region the previous cycle's address hit; steers the load mux.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_IO
  } sel_e;

  logic              ram_hit;
  logic              io_hit;
  logic [7:0]        offset;
  logic              wr_io;
  logic              wr_edge;
  logic              wr_timer;

  sel_e              sel_q;
  logic [31:0]       io_rdata;
  logic [31:0]       io_rdata_q;

  logic [31:0]       out_q [NUM_OUT];
  logic [31:0]       timer_q;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] edge_q;
  logic [NUM_BTN-1:0] edge_d;
  logic [NUM_BTN-1:0] edge_clr;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  // Address decode; RAM wins should the two regions ever be made to overlap.
  always_comb begin
    ram_hit  = ({1'b0, address_dmem} < RAM_LIMIT);
    io_hit   = (address_dmem[31:8] == IO_BASE[31:8]) && !ram_hit;
    offset   = address_dmem[7:0];
    wr_io    = wren && io_hit;
    wr_edge  = wr_io && (offset == OFF_EDGE);
    wr_timer = wr_io && (offset == OFF_TIMER);
  end

  assign ram_addr   = address_dmem[ADDR_WIDTH-1:0];
  assign ram_dataIn = data;
  // Gate with reset so a store during reset cannot corrupt RAM.
  assign ram_wEn    = wren && ram_hit && !reset;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_regs[32*g +: 32] = out_q[g];
  end

  // I/O read value from current (pre-update) state, so a read racing a write
  // returns the old contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    io_rdata = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (offset == 8'(i)) io_rdata = out_q[i];
    end
    case (offset)
      OFF_LEVEL: io_rdata = 32'(level_q);
      OFF_EDGE:  io_rdata = 32'(edge_q);
      OFF_TIMER: io_rdata = timer_q;
      default:   ;
    endcase
  end

  // Debounce and edge capture: a bit's level only follows the synchronised
  // input after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) level_d[i] = sync2_q[i];
        else                     cnt_d[i]   = cnt_q[i] + 1'b1;
      end
    end
    edge_clr = wr_edge ? data[NUM_BTN-1:0] : '0;
    // A new rising edge beats a simultaneous write-1-to-clear.
    edge_d   = (edge_q & ~edge_clr) | (level_d & ~level_q);
  end

  // Button synchroniser, debounce state, sticky edges and irq.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      edge_q  <= '0;
      irq     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      edge_q  <= edge_d;
      irq     <= |edge_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Output registers, written at the store edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: this array is a handful of flops driving board pins, so it is
      // reset explicitly; the external data RAM is deliberately left alone.
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
    end else if (wr_io) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (offset == 8'(i)) out_q[i] <= data;
      end
    end
  end

  // Free-running timer; a store loads it instead of incrementing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         timer_q <= '0;
    else if (wr_timer) timer_q <= data;
    else               timer_q <= timer_q + 32'd1;
  end

  // Register the region select and I/O read value for the 1-cycle load path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q      <= SEL_NONE;
      io_rdata_q <= '0;
    end else begin
      if (ram_hit)     sel_q <= SEL_RAM;
      else if (io_hit) sel_q <= SEL_IO;
      else             sel_q <= SEL_NONE;
      io_rdata_q <= io_rdata;
    end
  end

  // Load data mux.
  always_comb begin
    case (sel_q)
      SEL_RAM: q_dmem = ram_dataOut;
      SEL_IO:  q_dmem = io_rdata_q;
      default: q_dmem = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with a short debounce window and a behavioural
// synchronous RAM on the memory side.
module tb_mmio_ctrl;

  localparam logic [31:0] IO = 32'h0000_F000;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [3:0]  btn;
  logic [63:0] out_regs;
  logic        irq;

  int vectors;
  int miscompares;

  logic [31:0] mem [4096];

  mmio_ctrl #(
    .ADDR_WIDTH(12), .IO_BASE(IO), .NUM_OUT(2), .NUM_BTN(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .ram_wEn(ram_wEn), .ram_addr(ram_addr),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut), .btn(btn),
    .out_regs(out_regs), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a; data = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] q);
    address_dmem = a; wren = 1'b0;
    tick();
    q = q_dmem;
  endtask

  task automatic test_reset();
    reset = 1'b1; address_dmem = 32'd5; data = 32'h1111_1111; wren = 1'b1; btn = '0;
    #1;
    vectors++;
    if (ram_wEn !== 1'b0) begin miscompares++; $display("FAIL reset_wen got %b want 0", ram_wEn); end
    vectors++;
    if (q_dmem !== 32'd0) begin miscompares++; $display("FAIL reset_q got %h want 0", q_dmem); end
    vectors++;
    if (out_regs !== 64'd0) begin miscompares++; $display("FAIL reset_out got %h want 0", out_regs); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
    wren = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] q;
    address_dmem = 32'd5; data = 32'hDEAD_BEEF; wren = 1'b1;
    #1;
    vectors++;
    if (ram_wEn !== 1'b1) begin miscompares++; $display("FAIL ram_wen_write got %b want 1", ram_wEn); end
    tick();
    wren = 1'b0;
    #1;
    vectors++;
    if (ram_wEn !== 1'b0) begin miscompares++; $display("FAIL ram_wen_idle got %b want 0", ram_wEn); end
    do_read(32'd5, q);
    vectors++;
    if (q !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ram_read got %h want deadbeef", q); end
    address_dmem = IO; wren = 1'b1;
    #1;
    vectors++;
    if (ram_wEn !== 1'b0) begin miscompares++; $display("FAIL ram_wen_io got %b want 0", ram_wEn); end
    wren = 1'b0;
  endtask

  task automatic test_out_regs();
    logic [31:0] q;
    do_write(IO + 32'd0, 32'h1234);
    vectors++;
    if (out_regs !== 64'h0000_0000_0000_1234) begin miscompares++; $display("FAIL out0_write got %h want 1234", out_regs); end
    do_write(IO + 32'd1, 32'hABCD);
    vectors++;
    if (out_regs !== {32'hABCD, 32'h1234}) begin miscompares++; $display("FAIL out1_write got %h want abcd_1234", out_regs); end
    do_read(IO + 32'd0, q);
    vectors++;
    if (q !== 32'h1234) begin miscompares++; $display("FAIL out0_read got %h want 1234", q); end
    do_read(IO + 32'd1, q);
    vectors++;
    if (q !== 32'hABCD) begin miscompares++; $display("FAIL out1_read got %h want abcd", q); end
    do_write(IO + 32'h05, 32'hFFFF_FFFF);
    address_dmem = 32'h0000_2000; data = 32'h5555_5555; wren = 1'b1;
    #1;
    vectors++;
    if (ram_wEn !== 1'b0) begin miscompares++; $display("FAIL unmapped_wen got %b want 0", ram_wEn); end
    tick();
    wren = 1'b0;
    vectors++;
    if (out_regs !== {32'hABCD, 32'h1234}) begin miscompares++; $display("FAIL ignored_writes got %h want abcd_1234", out_regs); end
    do_read(IO + 32'h05, q);
    vectors++;
    if (q !== 32'd0) begin miscompares++; $display("FAIL hole_read got %h want 0", q); end
    do_read(32'h0000_2000, q);
    vectors++;
    if (q !== 32'd0) begin miscompares++; $display("FAIL unmapped_read got %h want 0", q); end
  endtask

  task automatic test_debounce();
    logic [31:0] q;
    address_dmem = IO; wren = 1'b0;
    btn = 4'b0001;
    repeat (3) tick();
    btn = 4'b0000;
    repeat (8) tick();
    do_read(IO + 32'h10, q);
    vectors++;
    if (q !== 32'd0) begin miscompares++; $display("FAIL glitch_level got %h want 0", q); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL glitch_irq got %b want 0", irq); end
    btn = 4'b0001;
    address_dmem = IO;
    repeat (5) tick();
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL early_irq got %b want 0", irq); end
    tick();
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL debounce_irq got %b want 1", irq); end
    do_read(IO + 32'h10, q);
    vectors++;
    if (q !== 32'h1) begin miscompares++; $display("FAIL debounce_level got %h want 1", q); end
    do_read(IO + 32'h11, q);
    vectors++;
    if (q !== 32'h1) begin miscompares++; $display("FAIL debounce_edge got %h want 1", q); end
  endtask

  task automatic test_edge_clear();
    logic [31:0] q;
    btn = 4'b0011; address_dmem = IO; wren = 1'b0;
    repeat (5) tick();
    address_dmem = IO + 32'h11; data = 32'h1; wren = 1'b1;
    tick();
    wren = 1'b0;
    vectors++;
    if (q_dmem !== 32'h1) begin miscompares++; $display("FAIL race_preclear got %h want 1", q_dmem); end
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL race_irq got %b want 1", irq); end
    do_read(IO + 32'h11, q);
    vectors++;
    if (q !== 32'h2) begin miscompares++; $display("FAIL race_edge got %h want 2", q); end
    address_dmem = IO + 32'h11; data = 32'h2; wren = 1'b1;
    tick();
    wren = 1'b0;
    vectors++;
    if (q_dmem !== 32'h2) begin miscompares++; $display("FAIL clear_preclear got %h want 2", q_dmem); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL clear_irq got %b want 0", irq); end
    do_read(IO + 32'h11, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL clear_edge got %h want 0", q); end
    do_read(IO + 32'h10, q);
    vectors++;
    if (q !== 32'h3) begin miscompares++; $display("FAIL both_levels got %h want 3", q); end
  endtask

  task automatic test_timer();
    logic [31:0] q;
    do_write(IO + 32'h12, 32'hFFFF_FFFE);
    do_read(IO + 32'h12, q);
    vectors++;
    if (q !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL timer_load got %h want fffffffe", q); end
    do_read(IO + 32'h12, q);
    vectors++;
    if (q !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL timer_inc got %h want ffffffff", q); end
    do_read(IO + 32'h12, q);
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL timer_wrap got %h want 0", q); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    btn = 4'b0000; address_dmem = IO; wren = 1'b0;
    repeat (8) tick();
    btn = 4'b1000;
    repeat (6) tick();
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL pre_reset_irq got %b want 1", irq); end
    btn = 4'b1100;
    repeat (4) tick();
    vectors++;
    if (q_dmem !== 32'h1234) begin miscompares++; $display("FAIL pre_reset_q got %h want 1234", q_dmem); end
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (out_regs !== 64'd0) begin miscompares++; $display("FAIL async_out got %h want 0", out_regs); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL async_irq got %b want 0", irq); end
    vectors++;
    if (q_dmem !== 32'd0) begin miscompares++; $display("FAIL async_q got %h want 0", q_dmem); end
    address_dmem = 32'd5; data = 32'h0BAD_0BAD; wren = 1'b1;
    #1;
    vectors++;
    if (ram_wEn !== 1'b0) begin miscompares++; $display("FAIL reset_ram_wen got %b want 0", ram_wEn); end
    wren = 1'b0; address_dmem = IO + 32'h12;
    tick();
    #2;
    reset = 1'b0;
    tick();
    vectors++;
    if (q_dmem !== 32'd0) begin miscompares++; $display("FAIL post_timer0 got %h want 0", q_dmem); end
    tick();
    vectors++;
    if (q_dmem !== 32'd1) begin miscompares++; $display("FAIL post_timer1 got %h want 1", q_dmem); end
    repeat (3) tick();
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL post_early_irq got %b want 0", irq); end
    tick();
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL post_irq got %b want 1", irq); end
    do_read(IO + 32'h10, q);
    vectors++;
    if (q !== 32'hC) begin miscompares++; $display("FAIL post_level got %h want c", q); end
    do_read(32'd5, q);
    vectors++;
    if (q !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ram_kept got %h want deadbeef", q); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_ram();
    test_out_regs();
    test_debounce();
    test_edge_clear();
    test_timer();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
